qnigma_tx_arb: RTL and testbench



---
 rtl/qnigma_pkg.sv | 23 ++
 rtl/qnigma_rr_pick.sv | 31 +++
 rtl/qnigma_tx_arb.sv | 180 ++++++++++++++++++
 tb/tb_qnigma_tx_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/qnigma_pkg.sv
// Shared qnigma stack types and constants.
// Transmit-source indices, TX arbiter FSM encoding, frame timing limits.
package qnigma_pkg;

  localparam int IFG                = 12;
  localparam int MTU_DEFAULT        = 1500;
  localparam int TX_ARB_GNT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    TX_SRC_ICMP = 2'd0,
    TX_SRC_TCP  = 2'd1,
    TX_SRC_UDP  = 2'd2,
    TX_SRC_DNS  = 2'd3
  } tx_src_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XMIT  = 2'd2,
    GAP   = 2'd3
  } tx_arb_fsm_t;

endpackage

// File: rtl/qnigma_rr_pick.sv
// Rotate-priority picker: first set req bit searching upward from last+1 (mod N).
// Latency: combinational.
// Backpressure: none; vld is low when no bit of req is set.
module qnigma_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] idx,
  output logic                 vld
);

  localparam int W = $clog2(N);

  logic [W-1:0] j;

  // Scan from farthest to nearest so the nearest requester overwrites the result.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    j   = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(last) + k) % N);
      if (req[j]) begin
        idx = j;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qnigma_tx_arb.sv
// Packet-granular TX arbiter muxing N frame sources onto the MAC; QNIGMA_TX_ARB_PRIO_EN favours source 0.
// Latency: grant 1 cycle after request in IDLE; data registered, 1 cycle after src_val.
// Backpressure: tx_rdy gates new grants only; frames are truncated at MAX_LEN, idle grants time out.
module qnigma_tx_arb #(
  parameter int N           = 4,
  parameter int IFG         = qnigma_pkg::IFG,
  parameter int MAX_LEN     = qnigma_pkg::MTU_DEFAULT + 14,
  parameter int GNT_TIMEOUT = qnigma_pkg::TX_ARB_GNT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         src_req,
  input  logic [N-1:0]         src_val,
  input  logic [N*8-1:0]       src_dat,
  output logic [N-1:0]         src_gnt,
  input  logic                 tx_rdy,
  output logic                 tx_val,
  output logic [7:0]           tx_dat,
  output logic                 tx_err,
  output logic [$clog2(N)-1:0] tx_src,
  output logic                 busy
);

  import qnigma_pkg::*;

  localparam int W = $clog2(N);

  tx_arb_fsm_t  state, state_nxt;
  logic [N-1:0] gnt_nxt;
  logic [W-1:0] src_nxt, last, last_nxt;
  logic         tval_nxt, terr_nxt;
  logic [7:0]   tdat_nxt;
  logic [15:0]  len, len_nxt, tmo, tmo_nxt, gap, gap_nxt;

  logic [7:0]   dat_arr [N];
  logic         cur_val, cur_req;
  logic [7:0]   cur_dat;
  logic [W-1:0] pick_idx;
  logic         pick_vld;

  always_comb begin
    for (int i = 0; i < N; i++) dat_arr[i] = src_dat[8*i +: 8];
  end

  assign cur_val = src_val[tx_src];
  assign cur_req = src_req[tx_src];
  assign cur_dat = dat_arr[tx_src];
  assign busy    = (state != IDLE);

`ifdef QNIGMA_TX_ARB_PRIO_EN
  // Sources 1..N-1 keep their own rotation pointer so interleaved
  // ICMP grants do not reset their fairness.
  logic [W-1:0] last_rr, lo_idx;
  logic         lo_vld;

  qnigma_rr_pick #(.N(N)) u_pick (
    .req  ({src_req[N-1:1], 1'b0}),
    .last (last_rr),
    .idx  (lo_idx),
    .vld  (lo_vld)
  );

  // Source 0 preempts unless it was the previous grantee and others are waiting.
  always_comb begin
    pick_vld = |src_req;
    pick_idx = lo_idx;
    if (src_req[0] && ((last != '0) || !lo_vld)) pick_idx = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rr <= W'(N - 1);
    end else if (state == IDLE && tx_rdy && pick_vld && pick_idx != '0) begin
      last_rr <= pick_idx;
    end
  end
`else
  qnigma_rr_pick #(.N(N)) u_pick (
    .req  (src_req),
    .last (last),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = src_gnt;
    src_nxt   = tx_src;
    last_nxt  = last;
    tval_nxt  = 1'b0;
    tdat_nxt  = tx_dat;
    terr_nxt  = 1'b0;
    len_nxt   = len;
    tmo_nxt   = tmo;
    gap_nxt   = gap;
    case (state)
      IDLE: begin
        len_nxt = '0;
        if (tx_rdy && pick_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = N'(1) << pick_idx;
          src_nxt   = pick_idx;
          last_nxt  = pick_idx;
          tmo_nxt   = '0;
        end
      end
      GRANT: begin
        if (cur_val) begin
          tval_nxt  = 1'b1;
          tdat_nxt  = cur_dat;
          len_nxt   = 16'd1;
          state_nxt = XMIT;
          if (16'd1 == 16'(MAX_LEN)) begin
            terr_nxt  = 1'b1;
            gnt_nxt   = '0;
            gap_nxt   = '0;
            state_nxt = GAP;
          end
        end else if (!cur_req || tmo == 16'(GNT_TIMEOUT - 1)) begin
          // Revoked grant: straight back to IDLE, no gap.
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          tmo_nxt = tmo + 16'd1;
        end
      end
      XMIT: begin
        if (cur_val) begin
          tval_nxt = 1'b1;
          tdat_nxt = cur_dat;
          len_nxt  = len + 16'd1;
          if (len + 16'd1 == 16'(MAX_LEN)) begin
            terr_nxt  = 1'b1;
            gnt_nxt   = '0;
            gap_nxt   = '0;
            state_nxt = GAP;
          end
        end else begin
          gnt_nxt   = '0;
          gap_nxt   = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        gnt_nxt = '0;
        if (gap == 16'(IFG - 1)) state_nxt = IDLE;
        else                     gap_nxt   = gap + 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      src_gnt <= '0;
      tx_src  <= '0;
      last    <= W'(N - 1);
      tx_val  <= 1'b0;
      tx_dat  <= '0;
      tx_err  <= 1'b0;
      len     <= '0;
      tmo     <= '0;
      gap     <= '0;
    end else begin
      state   <= state_nxt;
      src_gnt <= gnt_nxt;
      tx_src  <= src_nxt;
      last    <= last_nxt;
      tx_val  <= tval_nxt;
      tx_dat  <= tdat_nxt;
      tx_err  <= terr_nxt;
      len     <= len_nxt;
      tmo     <= tmo_nxt;
      gap     <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_qnigma_tx_arb.sv
// Directed-sequence bench for qnigma_tx_arb with random payloads and a grant-order model.
module tb_qnigma_tx_arb;

  localparam int N    = 4;
  localparam int MAXL = qnigma_pkg::MTU_DEFAULT + 14;
  localparam int GAPC = qnigma_pkg::IFG;
  localparam int TMO  = qnigma_pkg::TX_ARB_GNT_TIMEOUT;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_req, src_val, src_gnt;
  logic [31:0] src_dat;
  logic        tx_rdy, tx_val, tx_err, busy;
  logic [7:0]  tx_dat;
  logic [1:0]  tx_src;

  int tests = 0;
  int fails = 0;
  int m_last, m_last_rr;
  int nfwd, ndrop, hi;
  int order [5];

  always #5 clk = ~clk;

  qnigma_tx_arb dut (
    .clk     (clk),
    .rst     (rst),
    .src_req (src_req),
    .src_val (src_val),
    .src_dat (src_dat),
    .src_gnt (src_gnt),
    .tx_rdy  (tx_rdy),
    .tx_val  (tx_val),
    .tx_dat  (tx_dat),
    .tx_err  (tx_err),
    .tx_src  (tx_src),
    .busy    (busy)
  );

  // Expected winner for the given request vector from the last-granted history.
  function automatic int exp_pick(input logic [3:0] req);
`ifdef QNIGMA_TX_ARB_PRIO_EN
    if (req[0] && m_last != 0) return 0;
    for (int k = 1; k < N; k++) begin
      int j;
      j = (m_last_rr - 1 + k) % (N - 1) + 1;
      if (req[j]) return j;
    end
    if (req[0]) return 0;
    return -1;
`else
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (req[j]) return j;
    end
    return -1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; src_req = '0; src_val = '0; src_dat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_last = N - 1; m_last_rr = N - 1;
  endtask

  task automatic wait_grant(input int exp_lat, input string tag);
    int lat;
    int e;
    lat = 0;
    e = exp_pick(src_req);
    do begin
      @(negedge clk);
      lat++;
    end while (src_gnt == 4'b0 && lat < 300);
    chk({tag, "_gnt"}, 32'(src_gnt), (e < 0) ? 32'd0 : (32'd1 << e));
    chk({tag, "_src"}, 32'(tx_src), 32'(e));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    m_last = e;
    if (e > 0) m_last_rr = e;
  endtask

  // Drives len bytes from source s; each byte is checked one cycle later on the MAC side.
  task automatic frame(input int s, input int len, input bit noise);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      src_val[s] = 1'b1;
      src_dat[8*s +: 8] = b;
      if (noise) begin
        src_val[3] = 1'($urandom);
        src_dat[31:24] = 8'hAA;
      end
      @(negedge clk);
      if (tx_val) nfwd++;
      if (i < MAXL) begin
        chk("byte_val", 32'(tx_val), 32'd1);
        chk("byte_dat", 32'(tx_dat), 32'(b));
        chk("byte_err", 32'(tx_err), 32'(i + 1 == MAXL));
      end else begin
        if (!tx_val) ndrop++;
        chk("drop_val", 32'(tx_val), 32'd0);
      end
    end
  endtask

  task automatic end_frame(input int s);
    src_val[s] = 1'b0;
    src_val[3] = 1'b0;
    @(negedge clk);
    chk("eof_val", 32'(tx_val), 32'd0);
    chk("eof_gnt", 32'(src_gnt), 32'd0);
    chk("eof_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    tx_rdy = 1'b1;
    do_reset();
    chk("rst_gnt", 32'(src_gnt), 32'd0);
    chk("rst_val", 32'(tx_val), 32'd0);
    chk("rst_dat", 32'(tx_dat), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_src", 32'(tx_src), 32'd0);

    // Two requesters: source 1 first, then source 2 after the inter-frame gap.
    src_req = 4'b0110;
    wait_grant(1, "t1");
    chk("t1_first", 32'(tx_src), 32'd1);
    frame(1, 60, 1'b0);
    src_req = 4'b0100;
    end_frame(1);
    wait_grant(GAPC + 1, "t1n");
    chk("t1_second", 32'(tx_src), 32'd2);
    frame(2, $urandom_range(1, 80), 1'b0);
    src_req = 4'b0000;
    end_frame(2);

    // All sources requesting continuously.
`ifdef QNIGMA_TX_ARB_PRIO_EN
    order = '{0, 1, 0, 2, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    src_req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_grant((f == 0) ? 1 : GAPC + 1, "rr");
      chk("rr_order", 32'(tx_src), 32'(order[f]));
      frame(order[f], 64, 1'b0);
      end_frame(order[f]);
    end

    // Grantee that never starts loses its grant without a gap.
    do_reset();
    src_req = 4'b1100;
    wait_grant(1, "to");
    chk("to_first", 32'(tx_src), 32'd2);
    hi = 1;
    repeat (100) begin
      @(negedge clk);
      if (src_gnt != 4'b0100) break;
      hi++;
    end
    chk("to_len", hi, TMO);
    chk("to_gnt0", 32'(src_gnt), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    wait_grant(1, "ton");
    chk("to_next", 32'(tx_src), 32'd3);

    // Grantee dropping its request before starting is revoked immediately.
    src_req = 4'b0100;
    @(negedge clk);
    chk("rv_gnt", 32'(src_gnt), 32'd0);
    chk("rv_busy", 32'(busy), 32'd0);
    wait_grant(1, "rvn");
    chk("rv_next", 32'(tx_src), 32'd2);
    src_req = 4'b0000;
    @(negedge clk);

    // Oversize frame is truncated at MAX_LEN.
    do_reset();
    src_req = 4'b0010;
    wait_grant(1, "tr");
    nfwd = 0; ndrop = 0;
    frame(1, MAXL + 5, 1'b0);
    chk("tr_fwd", nfwd, MAXL);
    chk("tr_drop", ndrop, 5);
    src_req = 4'b0000;
    end_frame(1);

    // Non-granted source 3 toggling its valid must not leak onto the MAC.
    do_reset();
    src_req = 4'b0001;
    wait_grant(1, "nz");
    frame(0, $urandom_range(20, 60), 1'b1);
    src_req = 4'b0000;
    end_frame(0);

    // Reset in the middle of a frame.
    do_reset();
    src_req = 4'b1010;
    wait_grant(1, "mr");
    frame(1, 20, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_val", 32'(tx_val), 32'd0);
    chk("mr_gnt", 32'(src_gnt), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_dat", 32'(tx_dat), 32'd0);
    chk("mr_err", 32'(tx_err), 32'd0);
    rst = 1'b0;
    src_val = '0;
    m_last = N - 1; m_last_rr = N - 1;
    wait_grant(1, "mra");
    chk("mr_lowest", 32'(tx_src), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
